// File: rtl/niosv_sram_pipelined.sv
`default_nettype none
// niosv_sram_pipelined: single-port SRAM slave with a pipelined Avalon-MM interface,
// out-of-range error responses and an optional post-reset zero-fill. Rev 1.0
module niosv_sram_pipelined #(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 125000,
   parameter int ADDR_W         = 17,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_W-1:0]     writedata,
   input  logic                  clken,
   input  logic                  reset_req,
   output logic                  waitrequest,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid,
   output logic [1:0]            response,
   output logic                  init_busy
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AW1   = ADDR_W + 1;
   localparam logic [AW1-1:0]   DEPTH_EXT = AW1'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

   localparam logic [1:0] ST_RESET = 2'd0;
   localparam logic [1:0] ST_INIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [1:0]        state;
   logic [IDX_W-1:0]  init_cnt;
   logic              accept;
   logic              do_write;
   logic              do_read;
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] rd_word;
   logic [1:0]        rd_resp;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_RESET;
         init_cnt <= '0;
      end else begin
         case (state)
            ST_RESET: begin
               init_cnt <= '0;
               state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
            end
            ST_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == LAST_IDX) begin
                  state <= ST_READY;
               end
            end
            default: state <= ST_READY;
         endcase
      end
   end

   // Hold-off is combinational so a deasserted clken/reset_req accepts in the same cycle.
   assign waitrequest = (state != ST_READY) | ~clken | reset_req;
   assign init_busy   = (state == ST_INIT);
   assign accept      = chipselect & (read | write) & ~waitrequest;
   assign do_write    = accept & write;
   assign do_read     = accept & read & ~write;
   assign in_range    = {1'b0, address} < DEPTH_EXT;
   assign idx         = address[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         mem[init_cnt] <= '0;
      end else if (do_write && in_range) begin
         for (int i = 0; i < BE_W; i++) begin
            if (byteenable[i]) begin
               mem[idx][i*8 +: 8] <= writedata[i*8 +: 8];
            end
         end
      end
   end

   assign rd_word = in_range ? mem[idx] : '0;
   assign rd_resp = in_range ? RESP_OKAY : RESP_SLVERR;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [1:0]        s1_resp;

   // Data/response registers only load on a valid read so they hold between pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_resp  <= RESP_OKAY;
      end else begin
         s1_valid <= do_read;
         if (do_read) begin
            s1_data <= rd_word;
            s1_resp <= rd_resp;
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic              s2_valid;
         logic [DATA_W-1:0] s2_data;
         logic [1:0]        s2_resp;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s2_valid <= 1'b0;
               s2_data  <= '0;
               s2_resp  <= RESP_OKAY;
            end else begin
               s2_valid <= s1_valid;
               if (s1_valid) begin
                  s2_data <= s1_data;
                  s2_resp <= s1_resp;
               end
            end
         end

         assign readdatavalid = s2_valid;
         assign readdata      = s2_data;
         assign response      = s2_resp;
      end else begin : g_lat1
         assign readdatavalid = s1_valid;
         assign readdata      = s1_data;
         assign response      = s1_resp;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_niosv_sram_pipelined.sv
`default_nettype none
// tb_niosv_sram_pipelined: two SRAM configurations on one shared command bus, each checked
// every cycle against a transaction-level model (word arrays plus a due-cycle read queue).
module tb_niosv_sram_pipelined;
   localparam int AW = 8;
   localparam int D1 = 100;
   localparam int L1 = 1;
   localparam int D2 = 16;
   localparam int L2 = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [AW-1:0] address = '0;
   logic [3:0]  byteenable = '0;
   logic        chipselect = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic        clken = 1'b1;
   logic        reset_req = 1'b0;

   logic        waitrequest1, readdatavalid1, init_busy1;
   logic [31:0] readdata1;
   logic [1:0]  response1;
   logic        waitrequest2, readdatavalid2, init_busy2;
   logic [31:0] readdata2;
   logic [1:0]  response2;

   always #5 clk = ~clk;

   niosv_sram_pipelined #(.DATA_W(32), .DEPTH(D1), .ADDR_W(AW), .READ_LATENCY(L1),
                          .CLEAR_ON_RESET(0)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .waitrequest(waitrequest1),
      .readdata(readdata1), .readdatavalid(readdatavalid1), .response(response1),
      .init_busy(init_busy1));

   niosv_sram_pipelined #(.DATA_W(32), .DEPTH(D2), .ADDR_W(AW), .READ_LATENCY(L2),
                          .CLEAR_ON_RESET(1)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .waitrequest(waitrequest2),
      .readdata(readdata2), .readdatavalid(readdatavalid2), .response(response2),
      .init_busy(init_busy2));

   typedef struct packed {
      int          due;
      logic [31:0] data;
      logic [1:0]  resp;
   } rd_t;

   logic [31:0] m1 [D1];
   logic [31:0] m2 [D2];
   rd_t         q1[$];
   rd_t         q2[$];
   int          k = 0;
   int          cyc = 0;
   logic [31:0] last_d1 = '0, last_d2 = '0;
   logic [1:0]  last_r1 = '0, last_r2 = '0;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // One clock: pre-edge handshake checks, edge-time model update, post-edge read checks.
   task automatic step();
      logic exp_w1, exp_w2, acc1, acc2;
      int   a;
      rd_t  e;
      if (!reset_n) begin
         k = 0;
         q1.delete();
         q2.delete();
         last_d1 = '0; last_d2 = '0; last_r1 = 2'b00; last_r2 = 2'b00;
         foreach (m2[i]) m2[i] = '0;
      end
      #1;
      exp_w1 = !(reset_n && k >= 1) || !clken || reset_req;
      exp_w2 = !(reset_n && k >= 1 + D2) || !clken || reset_req;
      chk("waitrequest1", 32'(waitrequest1), 32'(exp_w1));
      chk("waitrequest2", 32'(waitrequest2), 32'(exp_w2));
      chk("init_busy1", 32'(init_busy1), 32'd0);
      chk("init_busy2", 32'(init_busy2), 32'(reset_n && k >= 1 && k <= D2));
      @(posedge clk);
      a    = int'(address);
      acc1 = chipselect && (read || write) && !exp_w1;
      acc2 = chipselect && (read || write) && !exp_w2;
      cyc++;
      if (reset_n) begin
         if (k < 1000) k++;
         if (acc1 && write && a < D1) m1[a] = merge(m1[a], writedata, byteenable);
         if (acc2 && write && a < D2) m2[a] = merge(m2[a], writedata, byteenable);
         if (acc1 && read && !write) begin
            e.due = cyc + L1 - 1;
            if (a < D1) begin e.data = m1[a]; e.resp = 2'b00; end
            else        begin e.data = '0;    e.resp = 2'b10; end
            q1.push_back(e);
         end
         if (acc2 && read && !write) begin
            e.due = cyc + L2 - 1;
            if (a < D2) begin e.data = m2[a]; e.resp = 2'b00; end
            else        begin e.data = '0;    e.resp = 2'b10; end
            q2.push_back(e);
         end
      end
      #1;
      acc1 = 1'b0;
      if (q1.size() > 0) if (q1[0].due == cyc) acc1 = 1'b1;
      if (acc1) begin last_d1 = q1[0].data; last_r1 = q1[0].resp; void'(q1.pop_front()); end
      acc2 = 1'b0;
      if (q2.size() > 0) if (q2[0].due == cyc) acc2 = 1'b1;
      if (acc2) begin last_d2 = q2[0].data; last_r2 = q2[0].resp; void'(q2.pop_front()); end
      chk("readdatavalid1", 32'(readdatavalid1), 32'(acc1));
      chk("readdata1", readdata1, last_d1);
      chk("response1", 32'(response1), 32'(last_r1));
      chk("readdatavalid2", 32'(readdatavalid2), 32'(acc2));
      chk("readdata2", readdata2, last_d2);
      chk("response2", 32'(response2), 32'(last_r2));
   endtask

   task automatic cmd(input logic r, input logic w, input int a, input logic [31:0] d,
                      input logic [3:0] be);
      chipselect = 1'b1; read = r; write = w;
      address = AW'(a); writedata = d; byteenable = be;
      step();
   endtask

   task automatic idle(input int n);
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #1 reset_n = 1'b0;
      idle(3);
      reset_n = 1'b1;
      idle(18);

      for (int a = 0; a < D1; a++) cmd(1'b0, 1'b1, a, $urandom, 4'hF);

      cmd(1'b0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
      cmd(1'b1, 1'b0, 5, 32'h0, 4'h0);
      chk("raw_lat1_data", readdata1, 32'hDEADBEEF);
      idle(1);
      chk("raw_lat2_data", readdata2, 32'hDEADBEEF);
      idle(2);

      cmd(1'b0, 1'b1, 7, 32'h11223344, 4'b1111);
      cmd(1'b0, 1'b1, 7, 32'hAABBCCDD, 4'b0101);
      cmd(1'b1, 1'b0, 7, 32'h0, 4'h0);
      chk("byteenable_merge", readdata1, 32'h11BB33DD);
      idle(3);

      cmd(1'b0, 1'b1, 0, 32'hA, 4'hF);
      cmd(1'b0, 1'b1, 1, 32'hB, 4'hF);
      cmd(1'b0, 1'b1, 2, 32'hC, 4'hF);
      cmd(1'b1, 1'b0, 0, 32'h0, 4'h0);
      cmd(1'b1, 1'b0, 1, 32'h0, 4'h0);
      chk("b2b_first_lat2", readdata2, 32'hA);
      cmd(1'b1, 1'b0, 2, 32'h0, 4'h0);
      idle(3);

      cmd(1'b0, 1'b1, 100, 32'h12345678, 4'hF);
      cmd(1'b1, 1'b0, 100, 32'h0, 4'h0);
      chk("oor_resp", 32'(response1), 32'd2);
      cmd(1'b1, 1'b0, 99, 32'h0, 4'h0);
      cmd(1'b0, 1'b1, 19, 32'hCAFEF00D, 4'hF);
      cmd(1'b1, 1'b0, 3, 32'h0, 4'h0);
      cmd(1'b1, 1'b1, 9, 32'h55AA55AA, 4'hF);
      cmd(1'b1, 1'b0, 9, 32'h0, 4'h0);
      idle(3);

      cmd(1'b1, 1'b0, 20, 32'h0, 4'h0);
      clken = 1'b0;
      cmd(1'b1, 1'b0, 21, 32'h0, 4'h0);
      cmd(1'b1, 1'b0, 21, 32'h0, 4'h0);
      cmd(1'b1, 1'b0, 21, 32'h0, 4'h0);
      clken = 1'b1;
      cmd(1'b1, 1'b0, 21, 32'h0, 4'h0);
      reset_req = 1'b1;
      cmd(1'b1, 1'b0, 4, 32'h0, 4'h0);
      cmd(1'b0, 1'b1, 4, 32'h0, 4'hF);
      reset_req = 1'b0;
      idle(3);

      for (int i = 0; i < 400; i++) begin
         clken     = ($urandom_range(0, 9) != 0);
         reset_req = ($urandom_range(0, 9) == 0);
         cmd(1'($urandom), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 127),
             $urandom, 4'($urandom));
         chipselect = ($urandom_range(0, 3) != 0);
      end
      clken = 1'b1; reset_req = 1'b0;

      cmd(1'b1, 1'b0, 6, 32'h0, 4'h0);
      chipselect = 1'b0; read = 1'b0;
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      idle(8);
      reset_n = 1'b0;
      idle(1);
      reset_n = 1'b1;
      idle(18);

      for (int a = 0; a < D1; a++) cmd(1'b1, 1'b0, a, 32'h0, 4'h0);
      idle(3);

      for (int i = 0; i < 200; i++) begin
         clken     = ($urandom_range(0, 7) != 0);
         reset_req = ($urandom_range(0, 9) == 0);
         cmd(1'($urandom), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 127),
             $urandom, 4'($urandom));
      end
      clken = 1'b1; reset_req = 1'b0;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
